exe_stage: RTL and testbench

- Consumer end of the ID/EX pipeline interface; takes the registered decode bundle and executes it.
- Generates Val2 (immediate rotate or shifted Rm), runs the 32-bit ALU, and computes the branch target.
- Owns the 4-bit status register (N, Z, C, V) and the EX/MEM pipeline register that feeds the memory stage.

---
 rtl/exe_pkg.sv | 25 ++
 rtl/exe_stage_val2_gen.sv | 52 +++++
 rtl/exe_stage.sv | 151 +++++++++++++++
 tb/tb_exe_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared constants for the execute stage: ALU commands,
// shift types and status-register bit positions.
package exe_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

endpackage

// File: rtl/exe_stage_val2_gen.sv
// Second-operand generator: rotated 8-bit immediate,
// 12-bit memory offset, or shifted Rm.
module val2_gen
  import exe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             imm,
  input  logic             mem_en,
  input  logic [11:0]      shift_operand,
  input  logic [WIDTH-1:0] val_rm,
  output logic [WIDTH-1:0] val2
);

  logic [WIDTH-1:0]   imm_ext;
  logic [WIDTH-1:0]   mem_ext;
  logic [4:0]         rot;
  logic [4:0]         amt;
  logic [2*WIDTH-1:0] imm_dbl;
  logic [2*WIDTH-1:0] rm_dbl;
  logic [WIDTH-1:0]   rm_sh;

  assign imm_ext = {{(WIDTH-8){1'b0}}, shift_operand[7:0]};
  assign mem_ext = {{(WIDTH-12){1'b0}}, shift_operand};
  assign rot     = {shift_operand[11:8], 1'b0};
  assign amt     = shift_operand[11:7];

  // Rotates are taken from the low half of a doubled word.
  assign imm_dbl = {imm_ext, imm_ext} >> rot;
  assign rm_dbl  = {val_rm, val_rm} >> amt;

  always_comb begin
    rm_sh = val_rm;
    unique case (shift_operand[6:5])
      SH_LSL: rm_sh = val_rm << amt;
      SH_LSR: rm_sh = val_rm >> amt;
      SH_ASR: rm_sh = $signed(val_rm) >>> amt;
      SH_ROR: rm_sh = rm_dbl[WIDTH-1:0];
      default: rm_sh = val_rm;
    endcase
  end

  always_comb begin
    if (imm)
      val2 = imm_dbl[WIDTH-1:0];
    else if (mem_en)
      val2 = mem_ext;
    else
      val2 = rm_sh;
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: Val2, ALU, status register, branch target and
// EX/MEM register. Define EXE_FORWARDING_EN to add operand forwarding.
module exe_stage
  import exe_pkg::*;
#(
  parameter int         WIDTH    = 32,
  parameter logic [3:0] SR_RESET = 4'b0000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             freeze,
  input  logic             WB_EN_In,
  input  logic             MEM_R_EN_In,
  input  logic             MEM_W_EN_In,
  input  logic             B_In,
  input  logic             S_In,
  input  logic [3:0]       EXE_CMD_In,
  input  logic [WIDTH-1:0] PC_In,
  input  logic [WIDTH-1:0] Val_Rn_In,
  input  logic [WIDTH-1:0] Val_Rm_In,
  input  logic             imm_In,
  input  logic [11:0]      Shift_operand_In,
  input  logic [23:0]      Signed_imm_24_In,
  input  logic [3:0]       Dest_In,
`ifdef EXE_FORWARDING_EN
  input  logic [1:0]       Sel_Src1,
  input  logic [1:0]       Sel_Src2,
  input  logic [WIDTH-1:0] MEM_ALU_Res,
  input  logic [WIDTH-1:0] WB_Value,
`endif
  output logic             Branch_Taken,
  output logic [WIDTH-1:0] Branch_Addr,
  output logic [3:0]       SR_Out,
  output logic             WB_EN_Out,
  output logic             MEM_R_EN_Out,
  output logic             MEM_W_EN_Out,
  output logic [WIDTH-1:0] ALU_Res_Out,
  output logic [WIDTH-1:0] Val_Rm_Out,
  output logic [3:0]       Dest_Out
);

  logic [WIDTH-1:0] rn;
  logic [WIDTH-1:0] rm;
  logic [WIDTH-1:0] val2;
  logic [WIDTH-1:0] add_b;
  logic             add_c;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic [WIDTH-1:0] res;
  logic             c_new;
  logic             v_new;
  logic [3:0]       sr;

`ifdef EXE_FORWARDING_EN
  always_comb begin
    rn = Val_Rn_In;
    unique case (Sel_Src1)
      2'b01:   rn = MEM_ALU_Res;
      2'b10:   rn = WB_Value;
      default: rn = Val_Rn_In;
    endcase
  end

  always_comb begin
    rm = Val_Rm_In;
    unique case (Sel_Src2)
      2'b01:   rm = MEM_ALU_Res;
      2'b10:   rm = WB_Value;
      default: rm = Val_Rm_In;
    endcase
  end
`else
  assign rn = Val_Rn_In;
  assign rm = Val_Rm_In;
`endif

  val2_gen #(.WIDTH(WIDTH)) u_val2 (
    .imm           (imm_In),
    .mem_en        (MEM_R_EN_In | MEM_W_EN_In),
    .shift_operand (Shift_operand_In),
    .val_rm        (rm),
    .val2          (val2)
  );

  // Subtracts run as Rn + ~Val2 + carry, so C comes out as NOT borrow.
  always_comb begin
    add_b = val2;
    add_c = 1'b0;
    unique case (EXE_CMD_In)
      CMD_ADC: add_c = sr[SR_C];
      CMD_SUB: begin add_b = ~val2; add_c = 1'b1; end
      CMD_SBC: begin add_b = ~val2; add_c = sr[SR_C]; end
      default: ;
    endcase
  end

  assign sum = {1'b0, rn} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_c};
  assign ovf = (rn[WIDTH-1] == add_b[WIDTH-1]) &&
               (sum[WIDTH-1] != rn[WIDTH-1]);

  always_comb begin
    res   = '0;
    c_new = sr[SR_C];
    v_new = sr[SR_V];
    unique case (EXE_CMD_In)
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
        res   = sum[WIDTH-1:0];
        c_new = sum[WIDTH];
        v_new = ovf;
      end
      CMD_AND: res = rn & val2;
      CMD_ORR: res = rn | val2;
      CMD_EOR: res = rn ^ val2;
      default: res = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      sr <= SR_RESET;
    else if (S_In && !freeze)
      sr <= {res[WIDTH-1], res == '0, c_new, v_new};
  end

  assign SR_Out = sr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      WB_EN_Out    <= 1'b0;
      MEM_R_EN_Out <= 1'b0;
      MEM_W_EN_Out <= 1'b0;
      ALU_Res_Out  <= '0;
      Val_Rm_Out   <= '0;
      Dest_Out     <= '0;
    end else if (!freeze) begin
      WB_EN_Out    <= WB_EN_In;
      MEM_R_EN_Out <= MEM_R_EN_In;
      MEM_W_EN_Out <= MEM_W_EN_In;
      ALU_Res_Out  <= res;
      Val_Rm_Out   <= rm;
      Dest_Out     <= Dest_In;
    end
  end

  assign Branch_Taken = B_In;
  assign Branch_Addr  = PC_In +
    {{6{Signed_imm_24_In[23]}}, Signed_imm_24_In, 2'b00};

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: vector table through a
// scoreboard queue, plus branch, freeze and async-reset sequences.
module tb_exe_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        freeze;
  logic        WB_EN_In, MEM_R_EN_In, MEM_W_EN_In, B_In, S_In;
  logic [3:0]  EXE_CMD_In;
  logic [31:0] PC_In, Val_Rn_In, Val_Rm_In;
  logic        imm_In;
  logic [11:0] Shift_operand_In;
  logic [23:0] Signed_imm_24_In;
  logic [3:0]  Dest_In;
  logic        Branch_Taken;
  logic [31:0] Branch_Addr;
  logic [3:0]  SR_Out;
  logic        WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out;
  logic [31:0] ALU_Res_Out, Val_Rm_Out;
  logic [3:0]  Dest_Out;

  always #5 CLK = ~CLK;

  exe_stage dut (
    .CLK              (CLK),
    .RST              (RST),
    .freeze           (freeze),
    .WB_EN_In         (WB_EN_In),
    .MEM_R_EN_In      (MEM_R_EN_In),
    .MEM_W_EN_In      (MEM_W_EN_In),
    .B_In             (B_In),
    .S_In             (S_In),
    .EXE_CMD_In       (EXE_CMD_In),
    .PC_In            (PC_In),
    .Val_Rn_In        (Val_Rn_In),
    .Val_Rm_In        (Val_Rm_In),
    .imm_In           (imm_In),
    .Shift_operand_In (Shift_operand_In),
    .Signed_imm_24_In (Signed_imm_24_In),
    .Dest_In          (Dest_In),
`ifdef EXE_FORWARDING_EN
    .Sel_Src1         (2'b00),
    .Sel_Src2         (2'b00),
    .MEM_ALU_Res      (32'h0),
    .WB_Value         (32'h0),
`endif
    .Branch_Taken     (Branch_Taken),
    .Branch_Addr      (Branch_Addr),
    .SR_Out           (SR_Out),
    .WB_EN_Out        (WB_EN_Out),
    .MEM_R_EN_Out     (MEM_R_EN_Out),
    .MEM_W_EN_Out     (MEM_W_EN_Out),
    .ALU_Res_Out      (ALU_Res_Out),
    .Val_Rm_Out       (Val_Rm_Out),
    .Dest_Out         (Dest_Out)
  );

  typedef struct {
    logic        wb, mr, mw, s, imm;
    logic [3:0]  cmd;
    logic [31:0] rn, rm;
    logic [11:0] so;
    logic [31:0] res;
    logic [3:0]  sr;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  sr;
    logic [2:0]  ctl;
    logic [31:0] rm;
    logic [3:0]  dest;
  } exp_t;

  int   tests = 0;
  int   failed = 0;
  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(
    logic wb, logic mr, logic mw, logic s, logic [3:0] cmd,
    logic [31:0] rn, logic [31:0] rm, logic imm, logic [11:0] so,
    logic [31:0] res, logic [3:0] sr);
    vec_t v;
    v.wb = wb; v.mr = mr; v.mw = mw; v.s = s; v.cmd = cmd;
    v.rn = rn; v.rm = rm; v.imm = imm; v.so = so;
    v.res = res; v.sr = sr;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v, logic [3:0] dest);
    WB_EN_In = v.wb; MEM_R_EN_In = v.mr; MEM_W_EN_In = v.mw;
    S_In = v.s; EXE_CMD_In = v.cmd;
    Val_Rn_In = v.rn; Val_Rm_In = v.rm;
    imm_In = v.imm; Shift_operand_In = v.so; Dest_In = dest;
  endtask

  task automatic check_out(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      tests++; failed++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, " res"}, ALU_Res_Out, e.res);
    chk({tag, " sr"}, {28'h0, SR_Out}, {28'h0, e.sr});
    chk({tag, " ctl"}, {29'h0, WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out},
        {29'h0, e.ctl});
    chk({tag, " rm"}, Val_Rm_Out, e.rm);
    chk({tag, " dest"}, {28'h0, Dest_Out}, {28'h0, e.dest});
  endtask

  task automatic step(vec_t v, logic [3:0] dest, string tag);
    exp_t e;
    @(negedge CLK);
    drive(v, dest);
    e.res = v.res; e.sr = v.sr; e.ctl = {v.wb, v.mr, v.mw};
    e.rm = v.rm; e.dest = dest;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    check_out(tag);
  endtask

  initial begin
    vec_t v;
    RST = 1'b1; freeze = 1'b0; B_In = 1'b0;
    PC_In = '0; Signed_imm_24_In = '0;
    drive(mk(0,0,0,0,4'h0,0,0,0,12'h0,0,4'h0), 4'h0);

    vecs.push_back(mk(1,0,0,1,4'b0010,32'h7FFFFFFF,0,1,12'h001,32'h80000000,4'b1001));
    vecs.push_back(mk(0,0,0,1,4'b0100,5,5,0,12'h000,0,4'b0110));
    vecs.push_back(mk(1,0,0,0,4'b0001,0,0,1,12'h2FF,32'hF000000F,4'b0110));
    vecs.push_back(mk(1,0,0,0,4'b0001,0,32'h80000000,0,12'h240,32'hF8000000,4'b0110));
    vecs.push_back(mk(1,0,0,1,4'b0011,1,0,1,12'h001,3,4'b0000));
    vecs.push_back(mk(1,0,0,1,4'b0101,10,0,1,12'h003,6,4'b0010));
    vecs.push_back(mk(1,0,0,0,4'b0001,0,32'hF0,0,12'h220,32'hF,4'b0010));
    vecs.push_back(mk(1,0,0,0,4'b0001,0,32'hF,0,12'h260,32'hF0000000,4'b0010));
    vecs.push_back(mk(1,0,0,0,4'b0001,0,1,0,12'hF80,32'h80000000,4'b0010));
    vecs.push_back(mk(1,0,0,1,4'b1001,0,0,1,12'h000,32'hFFFFFFFF,4'b1010));
    vecs.push_back(mk(0,0,0,1,4'b0110,32'hF0,0,1,12'h00F,0,4'b0110));
    vecs.push_back(mk(1,0,0,0,4'b0111,32'hF0,32'hF,0,12'h000,32'hFF,4'b0110));
    vecs.push_back(mk(1,0,0,1,4'b1000,32'hFF00,0,1,12'h0FF,32'hFFFF,4'b0010));
    vecs.push_back(mk(1,0,0,1,4'b0000,32'h1234,0,1,12'h0FF,0,4'b0110));
    vecs.push_back(mk(1,1,0,0,4'b0010,32'h400,0,0,12'h004,32'h404,4'b0110));
    vecs.push_back(mk(0,0,1,0,4'b0010,32'h1000,32'hDEADBEEF,0,12'hFFF,32'h1FFF,4'b0110));
    vecs.push_back(mk(1,0,0,1,4'b0100,32'h80000000,0,1,12'h001,32'h7FFFFFFF,4'b0011));
    vecs.push_back(mk(1,0,0,0,4'b0001,0,0,1,12'hF3F,32'hFC,4'b0011));
    vecs.push_back(mk(0,0,0,0,4'b0000,0,0,0,12'h000,0,4'b0011));

    #2;
    chk("reset res", ALU_Res_Out, 32'h0);
    chk("reset sr", {28'h0, SR_Out}, 32'h0);
    chk("reset ctl", {29'h0, WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out}, 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i], 4'(i), $sformatf("vec%0d", i));

    // Branch target and taken flag are combinational.
    @(negedge CLK);
    B_In = 1'b1; PC_In = 32'h100; Signed_imm_24_In = 24'hFFFFFE;
    #1;
    chk("br taken", {31'h0, Branch_Taken}, 32'h1);
    chk("br addr back", Branch_Addr, 32'h0F8);
    PC_In = 32'h0; Signed_imm_24_In = 24'h000010;
    #1;
    chk("br addr fwd", Branch_Addr, 32'h40);
    B_In = 1'b0;
    #1;
    chk("br not taken", {31'h0, Branch_Taken}, 32'h0);

    // Freeze holds EX/MEM and SR while an S=1 LDR waits.
    @(negedge CLK);
    v = mk(1,1,0,1,4'b0010,32'h400,32'hAA,0,12'h004,32'h404,4'b0000);
    drive(v, 4'h9);
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("frz%0d res", k), ALU_Res_Out, 32'h0);
      chk($sformatf("frz%0d sr", k), {28'h0, SR_Out}, 32'h3);
      chk($sformatf("frz%0d wb", k), {31'h0, WB_EN_Out}, 32'h0);
    end
    @(negedge CLK);
    freeze = 1'b0;
    step(v, 4'h9, "unfrz");

    // Async reset mid-cycle, with freeze high, after an SR write.
    step(mk(1,0,0,1,4'b0100,5,32'h55,1,12'h003,2,4'b0010), 4'h7, "pre_rst");
    @(negedge CLK);
    freeze = 1'b1;
    #2;
    RST = 1'b1;
    #1;
    chk("rst sr", {28'h0, SR_Out}, 32'h0);
    chk("rst res", ALU_Res_Out, 32'h0);
    chk("rst rm", Val_Rm_Out, 32'h0);
    chk("rst dest", {28'h0, Dest_Out}, 32'h0);
    chk("rst ctl", {29'h0, WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out}, 32'h0);
    @(negedge CLK);
    RST = 1'b0; freeze = 1'b0;
    @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
